read_mem: RTL and testbench
===========================

Name: read_mem

Overview:
- Readout side of the logic-analyzer capture buffer.
- Once capture has stopped, walks the circular sample buffer in chronological order (oldest first) and streams each sample out on a valid/ready interface, e.g. to the UART/host transmitter.
- Uses the buffer writer's final write address and primed flag to decide the start point and the sample count.
- Owns the buffer's read port; synchronous-read memory with 1-cycle latency.

Parameters:
- DATA_WIDTH, 8, sample width in bits; must be >= ADDR_WIDTH+1.
- ADDR_WIDTH, 4, buffer address width.
- MEMORY_SIZE, 2**ADDR_WIDTH, buffer depth in samples.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request to begin readout; honoured only in IDLE
- primed  in  1  writer has wrapped the buffer at least once
- waddr  in  ADDR_WIDTH  writer's next-write address (oldest sample when primed); stable while busy
- raddr  out  ADDR_WIDTH  buffer read address, registered
- rdata  in  DATA_WIDTH  buffer read data; valid the cycle after raddr is presented
- tdata  out  DATA_WIDTH  output sample
- tvalid  out  1  tdata valid
- tready  in  1  downstream accepts the beat
- tlast  out  1  marks the final beat of the dump
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse when readout completes

Behaviour:
- Reset values: raddr=0, tdata=0, tvalid=0, tlast=0, busy=0, done=0, state=IDLE. Reset mid-dump aborts it: tvalid drops at that edge, no done pulse.
- start accepted only in IDLE. On acceptance, latch:
  - base = primed ? waddr : 0
  - count (ADDR_WIDTH+1 bits) = primed ? MEMORY_SIZE : zero-extended waddr
  - raddr = base
  - busy = 1
- start while busy is ignored.
- States:
  - IDLE: waits for start. Exit to ADDR if count > 0, else to DONE.
  - ADDR: memory samples raddr. Always moves to CAPT.
  - CAPT: tdata <= rdata, tvalid <= 1, tlast <= (remaining == 1). Moves to SEND.
  - SEND: holds tdata/tvalid/tlast stable until tvalid & tready.
    - On handshake: tvalid <= 0, remaining decrements, raddr <= raddr+1 (mod MEMORY_SIZE, natural wrap 15->0).
    - Then DONE if remaining was 1, else ADDR.
  - DONE: done = 1 for one cycle, busy = 0, return to IDLE.
- Handshake rules:
  - tvalid never deasserts without a handshake (except on reset).
  - tdata never changes while tvalid=1.
  - tready may be high early; no combinational path from tready to tvalid.
- Throughput: at most 1 beat per 3 cycles. Latency from start to first tvalid = 3 cycles.
- Ordering:
  - primed: waddr, waddr+1, ..., waddr-1 (MEMORY_SIZE beats).
  - unprimed: 0 .. waddr-1.
- Empty buffer (unprimed, waddr=0): no beats, done pulses 2 cycles after start.

Optional Feature:
- Macro READ_MEM_HEADER_EN.
- Defined:
  - Before the first sample, emit one header beat: tdata = count zero-extended to DATA_WIDTH, with the same valid/ready rules (extra HDR state between IDLE and ADDR).
  - tlast stays on the final sample.
  - If count = 0, the header carries tlast=1, then DONE.
- Undefined: no header; behaviour exactly as above.

Decomposition:
- Shared package holds: DATA_WIDTH/ADDR_WIDTH/MEMORY_SIZE constants, the state encoding typedef (IDLE, HDR, ADDR, CAPT, SEND, DONE), and the count width ADDR_WIDTH+1.
- No sub-module needed; optionally factor a one-entry output register slice (read_mem_oreg) holding tdata/tvalid/tlast.

Test Plan (MEMORY_SIZE=16, DATA_WIDTH=8; memory model preloaded mem[i]=8'hA0+i, synchronous read):
- Unprimed, waddr=5, start, tready=1 -> 5 beats A0..A4, tlast only on A4, done 1 cycle after last handshake, first tvalid 3 cycles after start.
- Primed, waddr=12, start, tready=1 -> 16 beats AC,AD,AE,AF,A0..AB; raddr wraps 15->0; tlast on AB.
- Unprimed, waddr=0, start -> no tvalid, done pulse 2 cycles after start, busy high only in between.
- Primed, waddr=0, tready random 30% -> 16 beats A0..AF in order; tdata/tvalid stable whenever tvalid=1 & tready=0; start pulses mid-dump ignored.
- Reset asserted after 3rd handshake of a 16-beat dump -> next edge tvalid=0, busy=0, raddr=0, no done; fresh start then dumps correctly.
- With READ_MEM_HEADER_EN, unprimed waddr=3 -> beats 03, A0, A1, A2 (tlast on A2); with waddr=0 -> single beat 00 with tlast=1.

Source files
------------

// File: rtl/read_mem_pkg.sv
// Shared constants and state encoding for the capture-buffer readout engine.
package read_mem_pkg;

    localparam int unsigned DATA_WIDTH  = 8;
    localparam int unsigned ADDR_WIDTH  = 4;
    localparam int unsigned MEMORY_SIZE = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_WIDTH   = ADDR_WIDTH + 1;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_HDR  = 3'd1;
    localparam state_t ST_ADDR = 3'd2;
    localparam state_t ST_CAPT = 3'd3;
    localparam state_t ST_SEND = 3'd4;
    localparam state_t ST_DONE = 3'd5;

endpackage

// File: rtl/read_mem.sv
// Streams the circular capture buffer out oldest-first on a valid/ready port.
// Define READ_MEM_HEADER_EN to prepend a beat carrying the sample count.
module read_mem #(
    parameter int unsigned DATA_WIDTH  = read_mem_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH  = read_mem_pkg::ADDR_WIDTH,
    parameter int unsigned MEMORY_SIZE = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  primed,
    input  logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] tdata,
    output logic                  tvalid,
    input  logic                  tready,
    output logic                  tlast,
    output logic                  busy,
    output logic                  done
);
    import read_mem_pkg::*;

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rem_q;
    logic [CNT_W-1:0] start_cnt;
    logic             hs;
`ifdef READ_MEM_HEADER_EN
    logic             hdr_q;
`endif

    // A primed buffer is full and its oldest sample sits at the write pointer.
    assign start_cnt = primed ? CNT_W'(MEMORY_SIZE) : {1'b0, waddr};
    assign hs        = tvalid & tready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
`ifdef READ_MEM_HEADER_EN
                    state_d = ST_HDR;
`else
                    state_d = (start_cnt != '0) ? ST_ADDR : ST_DONE;
`endif
                end
            end
            ST_HDR:  state_d = ST_SEND;
            ST_ADDR: state_d = ST_CAPT;
            ST_CAPT: state_d = ST_SEND;
            ST_SEND: begin
                if (hs) begin
`ifdef READ_MEM_HEADER_EN
                    if (hdr_q) state_d = (rem_q != '0) ? ST_ADDR : ST_DONE;
                    else       state_d = (rem_q == CNT_W'(1)) ? ST_DONE : ST_ADDR;
`else
                    state_d = (rem_q == CNT_W'(1)) ? ST_DONE : ST_ADDR;
`endif
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            raddr   <= '0;
            tdata   <= '0;
            tvalid  <= 1'b0;
            tlast   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rem_q   <= '0;
`ifdef READ_MEM_HEADER_EN
            hdr_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            done    <= (state_q == ST_DONE);
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        raddr <= primed ? waddr : '0;
                        rem_q <= start_cnt;
                        busy  <= 1'b1;
                    end
                end
`ifdef READ_MEM_HEADER_EN
                ST_HDR: begin
                    tdata  <= DATA_WIDTH'(rem_q);
                    tvalid <= 1'b1;
                    tlast  <= (rem_q == '0);
                    hdr_q  <= 1'b1;
                end
`endif
                ST_CAPT: begin
                    tdata  <= rdata;
                    tvalid <= 1'b1;
                    tlast  <= (rem_q == CNT_W'(1));
                end
                ST_SEND: begin
                    if (hs) begin
                        tvalid <= 1'b0;
`ifdef READ_MEM_HEADER_EN
                        hdr_q  <= 1'b0;
                        if (!hdr_q) begin
                            rem_q <= rem_q - CNT_W'(1);
                            raddr <= raddr + ADDR_WIDTH'(1);
                        end
`else
                        rem_q  <= rem_q - CNT_W'(1);
                        raddr  <= raddr + ADDR_WIDTH'(1);
`endif
                    end
                end
                ST_DONE: busy <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_read_mem.sv
// Directed bench for read_mem: synchronous-read buffer model preloaded with A0+i.
module tb_read_mem;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;
    localparam int unsigned MS = 16;
`ifdef READ_MEM_HEADER_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif
    localparam int LAT = HDR ? 2 : 3;

    logic          clk = 1'b0;
    logic          reset, start, primed, tready;
    logic [AW-1:0] waddr, raddr;
    logic [DW-1:0] rdata, tdata;
    logic          tvalid, tlast, busy, done;

    logic [DW-1:0] mem [MS];
    logic [DW-1:0] exp_q [$];
    int            n_vec = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rdata <= mem[raddr];

    read_mem #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MEMORY_SIZE(MS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .primed(primed),
        .waddr (waddr),
        .raddr (raddr),
        .rdata (rdata),
        .tdata (tdata),
        .tvalid(tvalid),
        .tready(tready),
        .tlast (tlast),
        .busy  (busy),
        .done  (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic build(input bit prm, input logic [AW-1:0] wa);
        int            n;
        logic [AW-1:0] a;
        exp_q.delete();
        n = prm ? MS : int'(wa);
        a = prm ? wa : '0;
        if (HDR) exp_q.push_back(DW'(n));
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(8'hA0 + DW'(a));
            a = a + AW'(1);
        end
    endtask

    // Leaves the bench on the negedge one cycle after the accepting edge.
    task automatic kick(input bit prm, input logic [AW-1:0] wa);
        @(negedge clk);
        primed = prm;
        waddr  = wa;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic collect(input int pct, input bit poke, input int abort_at);
        int          got = 0;
        int          cyc = 1;
        int          first = -1;
        int          last_hs = -1;
        int          n = exp_q.size();
        bit          stall = 1'b0;
        logic [DW:0] held = '0;
        check("busy_set", busy, 1);
        while (cyc < 600) begin
            start = 1'b0;
            if (stall) begin
                check("hold_valid", tvalid, 1);
                check("hold_data", {tlast, tdata}, held);
            end
            if (tvalid && first < 0) first = cyc;
            if (done) break;
            if (abort_at != 0 && got == abort_at) return;
            tready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
            if (poke && (cyc % 7 == 0)) start = 1'b1;
            if (tvalid && tready) begin
                if (got < n) begin
                    check("beat_data", tdata, exp_q[got]);
                    if (!(HDR && got == 0)) check("raddr", raddr, AW'(exp_q[got]));
                end else begin
                    check("beat_extra", got + 1, n);
                end
                check("beat_last", tlast, got == n - 1);
                last_hs = cyc;
                got++;
            end
            stall = tvalid && !tready;
            held  = {tlast, tdata};
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("done_seen", done, 1);
        check("busy_clear", busy, 0);
        check("beat_total", got, n);
        check("first_valid_cyc", first, (n > 0) ? LAT : -1);
        check("done_cyc", cyc, (n > 0) ? last_hs + 2 : 2);
        @(negedge clk);
        check("done_pulse", done, 0);
    endtask

    initial begin
        for (int i = 0; i < int'(MS); i++) mem[i] = 8'hA0 + DW'(i);
        reset  = 1'b1;
        start  = 1'b0;
        primed = 1'b0;
        waddr  = '0;
        tready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_raddr", raddr, 0);
        check("rst_tdata", tdata, 0);
        check("rst_tvalid", tvalid, 0);
        check("rst_tlast", tlast, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b0;

        build(1'b0, 4'd5);  kick(1'b0, 4'd5);  collect(100, 1'b0, 0);
        build(1'b1, 4'd12); kick(1'b1, 4'd12); collect(100, 1'b0, 0);
        build(1'b0, 4'd0);  kick(1'b0, 4'd0);  collect(100, 1'b0, 0);
        build(1'b1, 4'd0);  kick(1'b1, 4'd0);  collect(30, 1'b1, 0);
        build(1'b0, 4'd3);  kick(1'b0, 4'd3);  collect(100, 1'b0, 0);

        // Abort a full dump after its third handshake.
        build(1'b1, 4'd0);  kick(1'b1, 4'd0);  collect(100, 1'b0, 3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_tvalid", tvalid, 0);
        check("abort_busy", busy, 0);
        check("abort_raddr", raddr, 0);
        check("abort_done", done, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
        end
        build(1'b1, 4'd7);  kick(1'b1, 4'd7);  collect(100, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
